// File: rtl/arb_pkg.sv
// Shared constants for the round-robin arbiter and its requester-side clients.
package arb_pkg;
    localparam int WIDTH_DEF   = 8;
    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 15;
    localparam int ARB_N       = 2;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and a read-data register loaded only on pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] rd_data_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign rd_data   = rd_data_r;
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and registered read data; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            rd_data_r <= {WIDTH{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r  <= rd_ptr_r + AW'(1);
                rd_data_r <= mem_r[rd_ptr_r];
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/arbiter_client.sv
// Requester-side arbiter endpoint: buffers upstream words, requests while non-empty,
// emits one word per grant and flags starvation and grant-without-request errors.
module arbiter_client
    import arb_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             request,
    input  logic             grant,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             starve_clr,
    output logic             starved,
    output logic             err_grant
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] TO_W = WW'(TIMEOUT);

    logic             full_s;
    logic             empty_s;
    logic [CW-1:0]    count_s;
    logic [WIDTH-1:0] rd_data_s;
    logic             push_s;
    logic             pop_s;
    logic [WW-1:0]    wait_cnt_r;
    logic [WW-1:0]    wait_nxt_s;
    logic             out_valid_r;
    logic             starved_r;
    logic             err_grant_r;

    // request and up_ready come from registered occupancy only, never from grant.
    assign up_ready  = !full_s;
    assign request   = !empty_s;
    assign push_s    = up_valid && !full_s;
    assign pop_s     = grant && !empty_s;
    assign out_valid = out_valid_r;
    assign out_data  = rd_data_s;
    assign starved   = starved_r;
    assign err_grant = err_grant_r;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .wr_data (up_data),
        .pop     (pop_s),
        .rd_data (rd_data_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count_s)
    );

    // Next wait count: cleared by grant or idle, saturating at TIMEOUT while waiting.
    always_comb begin
        wait_nxt_s = wait_cnt_r;
        if (grant || empty_s) begin
            wait_nxt_s = {WW{1'b0}};
        end else if (wait_cnt_r != TO_W) begin
            wait_nxt_s = wait_cnt_r + WW'(1);
        end else begin
            wait_nxt_s = wait_cnt_r;
        end
    end

    // Output strobe, wait counter and sticky flags; a starvation set beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            wait_cnt_r  <= {WW{1'b0}};
            starved_r   <= 1'b0;
            err_grant_r <= 1'b0;
        end else begin
            out_valid_r <= pop_s;
            wait_cnt_r  <= wait_nxt_s;
            if ((wait_nxt_s == TO_W) && (wait_cnt_r != TO_W)) begin
                starved_r <= 1'b1;
            end else if (starve_clr) begin
                starved_r <= 1'b0;
            end else begin
                starved_r <= starved_r;
            end
            if (grant && empty_s) begin
                err_grant_r <= 1'b1;
            end else begin
                err_grant_r <= err_grant_r;
            end
        end
    end
endmodule

// File: tb/tb_arbiter_client.sv
// Directed, scoreboard-based bench for arbiter_client with default parameters.
module tb_arbiter_client;
    logic       clk;
    logic       rst;
    logic       up_valid;
    logic       up_ready;
    logic [7:0] up_data;
    logic       request;
    logic       grant;
    logic       out_valid;
    logic [7:0] out_data;
    logic       starve_clr;
    logic       starved;
    logic       err_grant;

    int         checks;
    int         failures;
    logic [7:0] sb_q[$];
    logic [7:0] exp_w;

    arbiter_client dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .request    (request),
        .grant      (grant),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .starve_clr (starve_clr),
        .starved    (starved),
        .err_grant  (err_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance past the edge, then score any output word against the queue.
    task automatic tick();
        @(posedge clk);
        #1;
        if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_w = sb_q.pop_front();
                chk("out_data", {24'd0, out_data}, {24'd0, exp_w});
            end
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        up_valid = 1'b1;
        up_data  = d;
        sb_q.push_back(d);
        tick();
        up_valid = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        up_valid   = 1'b0;
        up_data    = 8'h00;
        grant      = 1'b0;
        starve_clr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_up_ready",  {31'd0, up_ready},  32'd1);
        chk("rst_request",   {31'd0, request},   32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {24'd0, out_data},  32'd0);
        chk("rst_starved",   {31'd0, starved},   32'd0);
        chk("rst_err_grant", {31'd0, err_grant}, 32'd0);
        rst = 1'b0;

        // Single word
        push_word(8'hA5);
        chk("single_request", {31'd0, request}, 32'd1);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        chk("single_out_valid", {31'd0, out_valid}, 32'd1);
        chk("single_request_drop", {31'd0, request}, 32'd0);
        tick();
        chk("single_pulse_end", {31'd0, out_valid}, 32'd0);
        chk("single_hold_data", {24'd0, out_data}, 32'hA5);

        // Fill to full, overflow ignored, drain back-to-back
        for (int i = 1; i <= 4; i++) begin
            push_word(8'(i));
        end
        chk("full_up_ready", {31'd0, up_ready}, 32'd0);
        up_valid = 1'b1;
        up_data  = 8'h55;
        tick();
        up_valid = 1'b0;
        chk("full_count", {29'd0, dut.count_s}, 32'd4);
        grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_out_valid", {31'd0, out_valid}, 32'd1);
        end
        grant = 1'b0;
        chk("drain_request", {31'd0, request}, 32'd0);
        chk("drain_sb_empty", sb_q.size(), 32'd0);

        // Simultaneous push and pop at count 2
        push_word(8'h20);
        push_word(8'h21);
        up_valid = 1'b1;
        up_data  = 8'h10;
        sb_q.push_back(8'h10);
        grant = 1'b1;
        tick();
        up_valid = 1'b0;
        chk("pushpop_count", {29'd0, dut.count_s}, 32'd2);
        tick();
        tick();
        grant = 1'b0;
        chk("pushpop_request", {31'd0, request}, 32'd0);

        // Starvation after exactly TIMEOUT request cycles, then clear
        push_word(8'h77);
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        chk("starve_early", {31'd0, starved}, 32'd0);
        tick();
        chk("starve_set", {31'd0, starved}, 32'd1);
        starve_clr = 1'b1;
        tick();
        starve_clr = 1'b0;
        chk("starve_clr", {31'd0, starved}, 32'd0);
        grant = 1'b1;
        tick();
        grant = 1'b0;

        // Grant in the 14th waiting cycle prevents starvation
        push_word(8'h78);
        push_word(8'h79);
        for (int i = 0; i < 12; i++) begin
            tick();
        end
        grant = 1'b1;
        tick();
        grant = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        chk("starve_prevented", {31'd0, starved}, 32'd0);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        chk("starve_sb_empty", sb_q.size(), 32'd0);

        // Grant with empty FIFO
        grant = 1'b1;
        tick();
        grant = 1'b0;
        chk("err_no_out", {31'd0, out_valid}, 32'd0);
        chk("err_set", {31'd0, err_grant}, 32'd1);
        tick();
        tick();
        chk("err_sticky", {31'd0, err_grant}, 32'd1);

        // Asynchronous reset with words queued
        push_word(8'h31);
        push_word(8'h32);
        push_word(8'h33);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_request", {31'd0, request}, 32'd0);
        chk("arst_up_ready", {31'd0, up_ready}, 32'd1);
        chk("arst_err_grant", {31'd0, err_grant}, 32'd0);
        sb_q.delete();
        #1;
        rst = 1'b0;
        grant = 1'b1;
        tick();
        grant = 1'b0;
        chk("arst_no_out", {31'd0, out_valid}, 32'd0);
        tick();
        chk("final_sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/arbiter_client.md
# arbiter_client

Requester-side endpoint for the two-request round-robin arbiter. It buffers upstream words in a small FIFO and holds `request` high while any word is pending. On each cycle where `grant` and `request` are both high, it pops one word and presents it on the shared output one cycle later. It also detects starvation (request held too long without grant) and protocol errors (grant with no request). One instance sits on each arbiter request line, and its `grant` input is driven from the matching arbiter `grants` bit.

## Interface
- `WIDTH`, 8: data word width in bits.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `TIMEOUT`, 15: consecutive request-without-grant cycles that trigger `starved`; range 1 .. 255.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `up_valid`  in  1  upstream word offered.
- `up_ready`  out  1  FIFO can accept a word this cycle.
- `up_data`  in  WIDTH  upstream word.
- `request`  out  1  to arbiter `requests[i]`.
- `grant`  in  1  from arbiter `grants[i]`.
- `out_valid`  out  1  one-cycle pulse: `out_data` is valid.
- `out_data`  out  WIDTH  granted word.
- `starve_clr`  in  1  clears `starved`.
- `starved`  out  1  sticky starvation flag.
- `err_grant`  out  1  sticky protocol error flag.

## Operation
- Push occurs when `up_valid && up_ready`.
- `up_ready = (count != DEPTH)`. It is derived from registered `count` only; a pop in the same cycle does not free a slot early.
- `request = (count != 0)`. It is combinational from registered state, with no path from `grant`.
- Pop occurs when `grant && request`; the FIFO head is removed.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- Order is strict FIFO. Read and write pointers wrap modulo DEPTH.
- Wait counter `wait_cnt`, width $clog2(TIMEOUT+1):
  - Cleared to 0 when `grant` is high or `request` is low.
  - Incremented when `request && !grant`.
  - Saturates at TIMEOUT.
- `starved`:
  - Set on the edge where `wait_cnt` becomes TIMEOUT.
  - Cleared by `starve_clr`.
  - If set and clear occur in the same cycle, set wins.
- `err_grant`: set when `grant && !request`. Cleared only by `rst`. Nothing is popped on that cycle.
- There is no state machine beyond FIFO occupancy. Conceptually the block has two states, IDLE (`count == 0`) and PENDING (`count > 0`).

## Timing
- Reset values: `up_ready=1`, `request=0`, `out_valid=0`, `out_data=0`, `starved=0`, `err_grant=0`, `count=0`, `wait_cnt=0`.
- Push-to-request latency: a word pushed at edge N makes `request` high in cycle N+1.
- Grant-to-output latency: a pop at edge N makes `out_valid` high with the popped word during cycle N+1, for one cycle.
- `out_data` holds its last value when `out_valid` is low.
- Back-to-back grants give back-to-back `out_valid` pulses, one word per cycle.
- `request` drops in the cycle after the last word is popped.
- Reset asserted mid-operation clears the FIFO, all flags and the counter immediately. Pending data is discarded and `request` falls without waiting for a clock.

## Structure
- Package `arb_pkg` holds:
  - default WIDTH, DEPTH and TIMEOUT constants;
  - the shared grant-vector width constant `ARB_N = 2`, used by arbiter and client tops.
- Sub-module `sync_fifo`: parameterised by WIDTH/DEPTH, with async active-high `rst`, push/pop, `full`/`empty` and `count` outputs, registered read data on pop. `arbiter_client` adds the request logic, wait counter and flags around it.

## Test plan
- Single word: push 0xA5 with `grant` low. `request`=1 next cycle. Drive `grant`=1 for one cycle → `out_valid` pulse with `out_data`=0xA5 the following cycle, then `request`=0.
- Fill to full: push 0x01–0x04 with no grant → `up_ready`=0 after the 4th push; a 5th push is ignored. Hold `grant`=1 for 4 cycles → outputs 0x01, 0x02, 0x03, 0x04 in consecutive cycles.
- Simultaneous push/pop: with count=2, push 0x10 while granted → count stays 2 and output order is preserved.
- Starvation (TIMEOUT=15): push one word and withhold grant → `starved`=1 after exactly 15 request cycles. Pulse `starve_clr` → `starved`=0. A grant on cycle 14 instead prevents `starved`.
- Protocol error: `grant`=1 with FIFO empty → `err_grant`=1 next cycle, no `out_valid`, and the flag stays until `rst`.
- Reset mid-run: with 3 words queued, assert `rst` between clock edges → `request`=0 and `up_ready`=1 immediately. After release, a grant produces no output.
